iob_bus_arbiter: RTL and testbench
==================================

Name: iob_bus_arbiter

Overview:
- Shares one native-memory slave port between two masters, e.g. the instruction and data buses of the CPU wrapper feeding a single-ported memory or external-memory controller.
- Arbitrates with round-robin or fixed priority and holds the grant for one full transaction (valid to ready).
- Passes the slave response back to the granted master only.

Parameters:
ADDR_W, 32, address width of every port
DATA_W, 32, data width; wstrb width is DATA_W/8
FIXED_PRIO, 0, 0 = round-robin, 1 = master 0 always wins ties

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
m0_req  input  REQ_W  master 0 request {valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}; REQ_W = 1+ADDR_W+DATA_W+DATA_W/8
m0_resp  output  RESP_W  master 0 response {rdata[DATA_W], ready}; RESP_W = DATA_W+1
m1_req  input  REQ_W  master 1 request, same format
m1_resp  output  RESP_W  master 1 response
s_req  output  REQ_W  shared slave request
s_resp  input  RESP_W  shared slave response
grant  output  1  index of the currently or last granted master (debug/observability)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Protocol, all ports:
  - A master raises valid with stable addr/wdata/wstrb and holds them until its ready pulse.
  - ready is asserted for exactly one cycle.
  - wstrb==0 means read; rdata is valid only in the ready cycle.
- FSM states:
  - IDLE: s_req.valid=0. If any master valid: pick the winner, register grant, go to BUSY.
  - BUSY: s_req = {1, fields of master[grant]}. When s_resp.ready=1 in this cycle: go to IDLE and update last_grant=grant.
- Latency:
  - Master valid at cycle t (arbiter IDLE) gives s_req.valid from t+1.
  - Slave ready at cycle r returns master ready combinationally at r.
  - s_req.valid drops at r+1.
  - Minimum bubble: one IDLE cycle between back-to-back transactions.
- Response routing:
  - m[grant]_resp = s_resp only while BUSY.
  - The other master, and both masters in IDLE, see ready=0 and rdata=0.
  - An s_resp.ready arriving in IDLE is ignored.
- Arbitration in IDLE:
  - One valid: grant it.
  - Both valid with FIXED_PRIO=1: master 0.
  - Both valid with FIXED_PRIO=0: the master != last_grant.
- Request fields are not registered; they are muxed from the granted master, relying on master hold stability. s_req.valid is a registered state bit.
- A master dropping valid mid-transaction is a protocol violation. The arbiter stays in BUSY until the slave's ready.
- Reset values:
  - state=IDLE, grant=0, last_grant=1 (so master 0 wins the first tie).
  - All s_req bits 0; both m*_resp 0.
- Reset mid-transaction: returns to IDLE next cycle. Any late slave ready is dropped and no master sees ready.
- No starvation in round-robin mode: a continuously valid master waits at most one foreign transaction.

Decomposition:
- Field widths, offsets and REQ_W/RESP_W go in the shared interconnect header:
  - valid/address/wdata/wstrb/rdata/ready bit positions.
  - The IDLE/BUSY state encoding localparams.
- One sub-module is natural: iob_rr_pick.
  - Combinational 2-input picker taking (valids, last_grant, FIXED_PRIO) and returning (any, winner).
  - Reusable when the arbiter is widened to N masters.

Test Plan:
- Single read: m0 valid addr=0x100, wstrb=0; slave ready with rdata=0xDEADBEEF 3 cycles after s_req.valid -> m0 ready for one cycle with 0xDEADBEEF; m1_resp stays 0; s_req.valid low the next cycle.
- Simultaneous requests after reset, FIXED_PRIO=0: m0 read 0x10 and m1 write 0x20/0xCAFE0000/wstrb=0xF -> m0 served first, then m1; s_req shows addr 0x10 then 0x20 with one IDLE cycle between.
- Round-robin fairness: both masters held valid for 6 transactions, slave ready 1 cycle after valid -> grant sequence 0,1,0,1,0,1 and 6 ready pulses total.
- Fixed priority: FIXED_PRIO=1, both continuously valid -> m0 granted every time and m1 never, until m0 drops valid; then m1 granted on the next IDLE.
- Reset mid-op: m1 granted and BUSY, rst pulsed 1 cycle before slave ready -> after reset s_req.valid=0, grant=0, m1 receives no ready; the next tie goes to m0.
- Stray response: s_resp.ready=1 while IDLE with no valids -> no ready on either master, state stays IDLE.

Source files
------------

// File: rtl/iob_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// iob_bus_arbiter_pkg
// Shared interconnect header for the native-memory (iob) bus arbiter.
//   - Arbiter FSM state encoding.
//   - Width and bit-position helpers for the packed request/response buses:
//       request  = {valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}
//       response = {rdata[DATA_W], ready}
// The positions depend on the instance widths, so they are provided as
// constant functions that modules evaluate into their own localparams.
// ---------------------------------------------------------------------------
package iob_bus_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Response bus field positions (independent of widths below rdata).
   localparam int RESP_READY_POS = 0;
   localparam int RESP_RDATA_LSB = 1;

   // Request bus: wstrb always sits at the bottom.
   localparam int REQ_WSTRB_LSB = 0;

   function automatic int req_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

   function automatic int resp_w(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int req_wdata_lsb(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int req_addr_lsb(input int data_w);
      return data_w + data_w / 8;
   endfunction

   function automatic int req_valid_pos(input int addr_w, input int data_w);
      return addr_w + data_w + data_w / 8;
   endfunction

endpackage

// File: rtl/iob_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// iob_rr_pick
// Combinational two-input winner picker.
//   i_valid      : per-master request valid (bit 0 = master 0)
//   i_last_grant : master that completed the most recent transaction
//   o_any        : at least one master is requesting
//   o_winner     : index of the master to grant
// A lone requester always wins. On a tie, FIXED_PRIO!=0 favours master 0,
// otherwise the master that was not served last wins (round-robin).
// ---------------------------------------------------------------------------
module iob_rr_pick #(
   parameter int FIXED_PRIO = 0
) (
   input  logic [1:0] i_valid,
   input  logic       i_last_grant,
   output logic       o_any,
   output logic       o_winner
);

   always_comb begin
      o_any    = |i_valid;
      o_winner = 1'b0;
      case (i_valid)
         2'b01:   o_winner = 1'b0;
         2'b10:   o_winner = 1'b1;
         2'b11:   o_winner = (FIXED_PRIO != 0) ? 1'b0 : ~i_last_grant;
         default: o_winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/iob_bus_arbiter.sv
// ---------------------------------------------------------------------------
// iob_bus_arbiter
// Shares one native-memory slave port between two masters. A winner is
// picked in IDLE, the grant is held for the whole transaction (valid until
// slave ready), and the slave response is routed to the granted master only.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   m0_req    : master 0 request  {valid, addr, wdata, wstrb}
//   m0_resp   : master 0 response {rdata, ready}
//   m1_req    : master 1 request
//   m1_resp   : master 1 response
//   s_req     : shared slave request
//   s_resp    : shared slave response
//   grant     : current / most recent granted master
// ---------------------------------------------------------------------------
module iob_bus_arbiter
   import iob_bus_arbiter_pkg::*;
#(
   parameter  int ADDR_W     = 32,
   parameter  int DATA_W     = 32,
   parameter  int FIXED_PRIO = 0,
   localparam int REQ_W      = req_w(ADDR_W, DATA_W),
   localparam int RESP_W     = resp_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REQ_W-1:0]  m0_req,
   output logic [RESP_W-1:0] m0_resp,
   input  logic [REQ_W-1:0]  m1_req,
   output logic [RESP_W-1:0] m1_resp,
   output logic [REQ_W-1:0]  s_req,
   input  logic [RESP_W-1:0] s_resp,
   output logic              grant
);

   localparam int VALID_POS = req_valid_pos(ADDR_W, DATA_W);

   state_t r_state;
   state_t w_state_nxt;
   logic   r_grant;
   logic   w_grant_nxt;
   logic   r_last_grant;
   logic   w_last_grant_nxt;
   logic   w_any;
   logic   w_winner;

   iob_rr_pick #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_pick (
      .i_valid     ({m1_req[VALID_POS], m0_req[VALID_POS]}),
      .i_last_grant(r_last_grant),
      .o_any       (w_any),
      .o_winner    (w_winner)
   );

   // last_grant resets to 1 so that master 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   // Request fields are muxed straight from the granted master (masters hold
   // them stable until ready); valid comes from the state bit, so a master
   // that drops valid early cannot abort a transaction the slave has seen.
   always_comb begin
      w_state_nxt      = r_state;
      w_grant_nxt      = r_grant;
      w_last_grant_nxt = r_last_grant;
      s_req            = '0;
      m0_resp          = '0;
      m1_resp          = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_BUSY;
               w_grant_nxt = w_winner;
            end
         end
         ST_BUSY: begin
            s_req            = r_grant ? m1_req : m0_req;
            s_req[VALID_POS] = 1'b1;
            if (r_grant) begin
               m1_resp = s_resp;
            end else begin
               m0_resp = s_resp;
            end
            if (s_resp[RESP_READY_POS]) begin
               w_state_nxt      = ST_IDLE;
               w_last_grant_nxt = r_grant;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign grant = r_grant;

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iob_bus_arbiter
// Two arbiter instances: index 0 round-robin, index 1 fixed priority.
// Master and slave models drive the buses; expected responses are queued by
// the stimulus and popped by an independent monitor on every ready pulse.
// ---------------------------------------------------------------------------
module tb_iob_bus_arbiter;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int REQ_W  = 1 + AW + DW + DW / 8;
   localparam int RESP_W = DW + 1;
   localparam int VB     = REQ_W - 1;

   typedef struct packed {
      logic        inst;
      logic        mst;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;

   logic clk;
   logic rst;

   logic [REQ_W-1:0]  m0_req [2];
   logic [REQ_W-1:0]  m1_req [2];
   logic [RESP_W-1:0] s_resp [2];

   logic [REQ_W-1:0]  s_req0, s_req1;
   logic [RESP_W-1:0] m0_resp0, m0_resp1, m1_resp0, m1_resp1;
   logic              grant0, grant1;

   logic [31:0] f_addr  [2][2];
   logic [31:0] f_wdata [2][2];
   logic [3:0]  f_wstrb [2][2];
   int          target  [2][2];
   int          done    [2][2];

   int          slv_delay [2];
   logic [31:0] slv_rdata [2];
   int          stray_seq [2];
   int          stray_ack [2];
   int          slv_cnt   [2];

   exp_t q[$];
   int   n_cmp;
   int   n_err;

   iob_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_dut_rr (
      .clk(clk), .rst(rst),
      .m0_req(m0_req[0]), .m0_resp(m0_resp0),
      .m1_req(m1_req[0]), .m1_resp(m1_resp0),
      .s_req(s_req0), .s_resp(s_resp[0]), .grant(grant0)
   );

   iob_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_dut_fp (
      .clk(clk), .rst(rst),
      .m0_req(m0_req[1]), .m0_resp(m0_resp1),
      .m1_req(m1_req[1]), .m1_resp(m1_resp1),
      .s_req(s_req1), .s_resp(s_resp[1]), .grant(grant1)
   );

   function automatic logic [REQ_W-1:0] sreq(int g);
      return (g == 0) ? s_req0 : s_req1;
   endfunction

   function automatic logic [RESP_W-1:0] mresp(int g, int m);
      if (g == 0) return (m == 0) ? m0_resp0 : m1_resp0;
      return (m == 0) ? m0_resp1 : m1_resp1;
   endfunction

   function automatic exp_t mk(logic g, logic m, logic [31:0] rd, logic [31:0] a,
                               logic [31:0] wd, logic [3:0] ws);
      exp_t e;
      e.inst = g; e.mst = m; e.rdata = rd; e.addr = a; e.wdata = wd; e.wstrb = ws;
      return e;
   endfunction

   function automatic bit pending();
      for (int g = 0; g < 2; g++)
         for (int m = 0; m < 2; m++)
            if (done[g][m] < target[g][m]) return 1'b1;
      return q.size() != 0;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (pending() && n < budget) begin
         @(posedge clk);
         n++;
      end
      #2;
      n_cmp++;
      if (n >= budget) begin
         n_err++;
         $display("FAIL %s: timeout with %0d responses outstanding", name, q.size());
         q.delete();
      end
   endtask

   task automatic set_master(input int g, input int m, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] ws, input int cnt);
      f_addr[g][m]  = a;
      f_wdata[g][m] = wd;
      f_wstrb[g][m] = ws;
      target[g][m]  = done[g][m] + cnt;
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Master model: holds valid and fields until the requested number of ready
   // pulses has been seen, then drops valid.
   initial begin
      bit                seen [2][2];
      logic [RESP_W-1:0] r;
      logic [REQ_W-1:0]  rq;
      for (int g = 0; g < 2; g++) begin
         m0_req[g] = '0;
         m1_req[g] = '0;
         for (int m = 0; m < 2; m++) done[g][m] = 0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++)
            for (int m = 0; m < 2; m++) begin
               r = mresp(g, m);
               seen[g][m] = r[0];
            end
         @(posedge clk);
         #1;
         for (int g = 0; g < 2; g++)
            for (int m = 0; m < 2; m++) begin
               if (seen[g][m]) done[g][m]++;
               rq = (done[g][m] < target[g][m]) ?
                    {1'b1, f_addr[g][m], f_wdata[g][m], f_wstrb[g][m]} : '0;
               if (m == 0) m0_req[g] = rq;
               else        m1_req[g] = rq;
            end
      end
   end

   // Slave model: answers slv_delay cycles after valid first appears; a
   // stray request forces a one-cycle ready regardless of s_req.
   initial begin
      logic [REQ_W-1:0] sr;
      for (int g = 0; g < 2; g++) begin
         s_resp[g]    = '0;
         slv_cnt[g]   = 0;
         stray_ack[g] = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int g = 0; g < 2; g++) begin
            sr = sreq(g);
            if (s_resp[g][0]) begin
               s_resp[g]  = '0;
               slv_cnt[g] = 0;
            end else if (stray_ack[g] != stray_seq[g]) begin
               stray_ack[g] = stray_seq[g];
               s_resp[g]    = {32'h0BAD_0BAD, 1'b1};
            end else if (sr[VB]) begin
               if (slv_cnt[g] == slv_delay[g]) begin
                  s_resp[g]  = {(sr[3:0] == 4'h0) ? slv_rdata[g] : 32'h0, 1'b1};
                  slv_cnt[g] = 0;
               end else begin
                  slv_cnt[g]++;
               end
            end else begin
               slv_cnt[g] = 0;
            end
         end
      end
   end

   // Monitor: pops one expectation per master ready pulse and checks the
   // one-cycle bubble after every completed transaction.
   initial begin
      bit                prev [2];
      logic [REQ_W-1:0]  sr;
      logic [RESP_W-1:0] r0, r1;
      exp_t              got, e;
      prev[0] = 1'b0;
      prev[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            sr = sreq(g);
            r0 = mresp(g, 0);
            r1 = mresp(g, 1);
            if (prev[g]) begin
               n_cmp++;
               if (sr[VB] !== 1'b0) begin
                  n_err++;
                  $display("FAIL bubble inst%0d: s_req.valid got %b expected 0", g, sr[VB]);
               end
            end
            if (r0[0] && r1[0]) begin
               n_cmp++;
               n_err++;
               $display("FAIL dual_ready inst%0d: both masters ready, expected one", g);
            end else if (r0[0] || r1[0]) begin
               got = mk(g[0], r1[0], r1[0] ? r1[RESP_W-1:1] : r0[RESP_W-1:1],
                        sr[VB-1 -: 32], sr[35:4], sr[3:0]);
               n_cmp++;
               if (q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_ready inst%0d: got %0h expected none", g, got);
               end else begin
                  e = q.pop_front();
                  if (got !== e) begin
                     n_err++;
                     $display("FAIL response inst%0d: got %0h expected %0h", g, got, e);
                  end
               end
            end
            prev[g] = r0[0] || r1[0];
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      for (int g = 0; g < 2; g++) begin
         slv_delay[g] = 1;
         slv_rdata[g] = '0;
         stray_seq[g] = 0;
         for (int m = 0; m < 2; m++) begin
            target[g][m]  = 0;
            f_addr[g][m]  = '0;
            f_wdata[g][m] = '0;
            f_wstrb[g][m] = '0;
         end
      end

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_sreq_rr",  64'(s_req0 != '0), 64'd0);
      chk("rst_grant_rr", 64'(grant0), 64'd0);
      chk("rst_m0resp",   64'(m0_resp0), 64'd0);
      chk("rst_m1resp",   64'(m1_resp0), 64'd0);
      chk("rst_sreq_fp",  64'(s_req1 != '0), 64'd0);
      chk("rst_grant_fp", 64'(grant1), 64'd0);

      // Single read, slave ready 3 cycles after valid
      tick();
      slv_delay[0] = 3;
      slv_rdata[0] = 32'hDEAD_BEEF;
      q.push_back(mk(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h100, 32'h0, 4'h0));
      set_master(0, 0, 32'h100, 32'h0, 4'h0, 1);
      @(negedge clk);
      @(negedge clk);
      chk("t1_idle_cycle", 64'(s_req0[VB]), 64'd0);
      @(negedge clk);
      chk("t1_sreq_valid", 64'(s_req0[VB]), 64'd1);
      chk("t1_sreq_addr",  64'(s_req0[VB-1 -: 32]), 64'h100);
      chk("t1_grant",      64'(grant0), 64'd0);
      drain("t1_drain", 50);

      // Stray slave ready while idle
      tick();
      stray_seq[0]++;
      @(negedge clk);
      @(negedge clk);
      chk("stray_m0resp", 64'(m0_resp0), 64'd0);
      chk("stray_m1resp", 64'(m1_resp0), 64'd0);
      chk("stray_valid",  64'(s_req0[VB]), 64'd0);
      @(negedge clk);
      chk("stray_idle",   64'(s_req0[VB]), 64'd0);

      // Simultaneous requests straight after reset: m0 first, then m1
      do_reset();
      tick();
      slv_delay[0] = 1;
      slv_rdata[0] = 32'h1111_2222;
      q.push_back(mk(1'b0, 1'b0, 32'h1111_2222, 32'h10, 32'h0, 4'h0));
      q.push_back(mk(1'b0, 1'b1, 32'h0, 32'h20, 32'hCAFE_0000, 4'hF));
      set_master(0, 0, 32'h10, 32'h0, 4'h0, 1);
      set_master(0, 1, 32'h20, 32'hCAFE_0000, 4'hF, 1);
      drain("t2_drain", 50);
      chk("t2_grant_last", 64'(grant0), 64'd1);

      // Round-robin fairness: 0,1,0,1,0,1
      tick();
      slv_rdata[0] = 32'h0F0F_0F0F;
      for (int i = 0; i < 6; i++)
         q.push_back(mk(1'b0, 1'(i % 2), 32'h0F0F_0F0F, (i % 2) ? 32'h44 : 32'h40,
                        32'h0, 4'h0));
      set_master(0, 0, 32'h40, 32'h0, 4'h0, 3);
      set_master(0, 1, 32'h44, 32'h0, 4'h0, 3);
      drain("rr_drain", 100);

      // Reset while m1 is granted; late slave ready must be dropped
      tick();
      slv_delay[0] = 5;
      slv_rdata[0] = 32'h55AA_55AA;
      set_master(0, 1, 32'h300, 32'h0, 4'h0, 1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("rm_grant_m1", 64'(grant0), 64'd1);
      chk("rm_busy",     64'(s_req0[VB]), 64'd1);
      tick();
      rst = 1'b1;
      stray_seq[0]++;
      q.push_back(mk(1'b0, 1'b0, 32'h55AA_55AA, 32'h500, 32'h0, 4'h0));
      q.push_back(mk(1'b0, 1'b1, 32'h55AA_55AA, 32'h300, 32'h0, 4'h0));
      set_master(0, 0, 32'h500, 32'h0, 4'h0, 1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rm_m0resp", 64'(m0_resp0), 64'd0);
      chk("rm_m1resp", 64'(m1_resp0), 64'd0);
      chk("rm_sreq",   64'(s_req0 != '0), 64'd0);
      chk("rm_grant",  64'(grant0), 64'd0);
      drain("rm_drain", 100);

      // Fixed priority: m0 three times, m1 only after m0 drops valid
      tick();
      slv_delay[1] = 1;
      slv_rdata[1] = 32'hA0A0_A0A0;
      for (int i = 0; i < 3; i++)
         q.push_back(mk(1'b1, 1'b0, 32'hA0A0_A0A0, 32'h600, 32'h0, 4'h0));
      q.push_back(mk(1'b1, 1'b1, 32'h0, 32'h700, 32'h1234_5678, 4'h3));
      set_master(1, 0, 32'h600, 32'h0, 4'h0, 3);
      set_master(1, 1, 32'h700, 32'h1234_5678, 4'h3, 1);
      drain("fp_drain", 100);
      chk("fp_grant_last", 64'(grant1), 64'd1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
